// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and frame constants for the USB full-speed receive bit timer.
// The 25-clock frame carries three bits of 8, 8 and 9 clocks.
`default_nettype none

package usb_rx_pkg;

  typedef logic [4:0] phase_t;
  typedef logic [3:0] bitcnt_t;

  localparam int     FRAME_LEN  = 25;
  localparam phase_t PHASE_LAST = phase_t'(FRAME_LEN - 1);
  localparam phase_t BIT_BND0   = 5'd0;
  localparam phase_t BIT_BND1   = 5'd8;
  localparam phase_t BIT_BND2   = 5'd16;

  function automatic logic is_sample_point(input phase_t p, input int offset);
    return (p == BIT_BND0 + phase_t'(offset)) ||
           (p == BIT_BND1 + phase_t'(offset)) ||
           (p == BIT_BND2 + phase_t'(offset));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: counts non-stuffed bits and pulses o_byte_received on the last bit of each byte.
`default_nettype none

module rx_bit_counter
  import usb_rx_pkg::*;
#(
  parameter int BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_shift_hit,
  input  logic       i_clear,
  output logic [3:0] o_bit_count,
  output logic       o_byte_received
);

  localparam bitcnt_t LAST_BIT = bitcnt_t'(BITS_PER_BYTE - 1);

  bitcnt_t r_bit_count;
  logic    r_byte_received;

  // Clearing discards a partial byte without ever reporting it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_count     <= '0;
      r_byte_received <= 1'b0;
    end else if (i_clear) begin
      r_bit_count     <= '0;
      r_byte_received <= 1'b0;
    end else begin
      r_byte_received <= 1'b0;
      if (i_shift_hit) begin
        if (r_bit_count == LAST_BIT) begin
          r_bit_count     <= '0;
          r_byte_received <= 1'b1;
        end else begin
          r_bit_count <= r_bit_count + 4'd1;
        end
      end
    end
  end

  assign o_bit_count     = r_bit_count;
  assign o_byte_received = r_byte_received;

endmodule

`default_nettype wire

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: recovers 12 Mbps receive bit timing from a 25-clock, three-bit phase frame.
// Define RX_TIMER_RESYNC_EN to re-align the phase on every line transition (d_edge).
`default_nettype none

module rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int SAMPLE_OFFSET = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_receiving,
  input  logic       i_d_edge,
  input  logic       i_unstuff,
  output logic       o_sample_strobe,
  output logic       o_shift_enable,
  output logic       o_byte_received,
  output logic [3:0] o_bit_count,
  output logic [4:0] o_phase
);

  phase_t r_phase;
  phase_t w_phase_next;
  logic   w_resync;
  logic   w_hit;
  logic   w_shift_hit;
  logic   r_sample_strobe;
  logic   r_shift_enable;

`ifdef RX_TIMER_RESYNC_EN
  assign w_resync = i_d_edge & i_receiving;
`else
  logic w_unused_d_edge;
  assign w_unused_d_edge = i_d_edge;
  assign w_resync        = 1'b0;
`endif

  // An edge cycle is treated as phase 0, so the following cycle is phase 1.
  always_comb begin
    w_phase_next = r_phase;
    if (!i_receiving)
      w_phase_next = '0;
    else if (w_resync)
      w_phase_next = 5'd1;
    else if (r_phase == PHASE_LAST)
      w_phase_next = '0;
    else
      w_phase_next = r_phase + 5'd1;
  end

  assign w_hit       = i_receiving && is_sample_point(r_phase, SAMPLE_OFFSET) && !w_resync;
  assign w_shift_hit = w_hit && !i_unstuff;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase         <= '0;
      r_sample_strobe <= 1'b0;
      r_shift_enable  <= 1'b0;
    end else begin
      r_phase         <= w_phase_next;
      r_sample_strobe <= w_hit;
      r_shift_enable  <= w_shift_hit;
    end
  end

  rx_bit_counter #(
    .BITS_PER_BYTE(BITS_PER_BYTE)
  ) u_bit_counter (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_shift_hit    (w_shift_hit),
    .i_clear        (!i_receiving),
    .o_bit_count    (o_bit_count),
    .o_byte_received(o_byte_received)
  );

  assign o_sample_strobe = r_sample_strobe;
  assign o_shift_enable  = r_shift_enable;
  assign o_phase         = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: scoreboard bench; the stimulus task queues expected strobe events, a monitor checks them.
`default_nettype none

module tb_rx_bit_timer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       receiving = 1'b0;
  logic       d_edge = 1'b0;
  logic       unstuff = 1'b0;
  logic       sample_strobe;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;
  logic [4:0] phase;

  typedef struct {
    int         cyc;
    logic       sh;
    logic       by;
    logic [3:0] bc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  rx_bit_timer #(
    .SAMPLE_OFFSET(3),
    .BITS_PER_BYTE(8)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_receiving    (receiving),
    .i_d_edge       (d_edge),
    .i_unstuff      (unstuff),
    .o_sample_strobe(sample_strobe),
    .o_shift_enable (shift_enable),
    .o_byte_received(byte_received),
    .o_bit_count    (bit_count),
    .o_phase        (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe event must match the next queued expectation.
  always @(negedge clk) begin
    if (n_rst && (sample_strobe || shift_enable || byte_received)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: cycle %0d ss=%b se=%b br=%b bc=%0d",
                 cyc, sample_strobe, shift_enable, byte_received, bit_count);
      end else begin
        m_e = q.pop_front();
        if (cyc != m_e.cyc || sample_strobe !== 1'b1 || shift_enable !== m_e.sh ||
            byte_received !== m_e.by || bit_count !== m_e.bc) begin
          n_err++;
          $display("FAIL strobe_event: got cyc=%0d ss=%b se=%b br=%b bc=%0d expected cyc=%0d ss=1 se=%b br=%b bc=%0d",
                   cyc, sample_strobe, shift_enable, byte_received, bit_count,
                   m_e.cyc, m_e.sh, m_e.by, m_e.bc);
        end
      end
    end
  end

  // Runs ncyc cycles of a packet (cycle 0 = receiving rise, phase 0) and queues expected events.
  // Returns at cycle ncyc (posedge + 1) with receiving still high.
  task automatic run_packet(input int ncyc, input int unstuff_at, input int edge_a,
                            input int edge_b, input int chk_k, input int chk_ph);
    int   base;
    int   mp;
    int   mbc;
    logic rs;
    logic hit;
    exp_t e;
    mp  = 0;
    mbc = 0;
    @(posedge clk); #1;
    base      = cyc;
    n_rst     = 1'b1;
    receiving = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      unstuff = (k == unstuff_at);
      d_edge  = (k == edge_a) || (k == edge_b);
      if (k == chk_k) check("phase_mid_packet", int'(phase), chk_ph);
`ifdef RX_TIMER_RESYNC_EN
      rs = d_edge;
`else
      rs = 1'b0;
`endif
      hit = (mp == 3 || mp == 11 || mp == 19) && !rs;
      if (hit) begin
        if (!unstuff) mbc = (mbc == 7) ? 0 : mbc + 1;
        e.cyc = base + k + 1;
        e.sh  = !unstuff;
        e.by  = !unstuff && (mbc == 0);
        e.bc  = 4'(mbc);
        q.push_back(e);
      end
      mp = rs ? 1 : ((mp == 24) ? 0 : mp + 1);
    end
    @(posedge clk); #1;
    unstuff = 1'b0;
    d_edge  = 1'b0;
  endtask

  task automatic drop_and_check(input string name);
    receiving = 1'b0;
    @(posedge clk); #1;
    check({name, "_phase"}, int'(phase), 0);
    check({name, "_bit_count"}, int'(bit_count), 0);
    check({name, "_strobes"}, int'({sample_strobe, shift_enable, byte_received}), 0);
    check({name, "_queue"}, q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Reset, then idle with receiving low.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({sample_strobe, shift_enable, byte_received, bit_count, phase}), 0);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_outputs", int'({sample_strobe, shift_enable, byte_received, bit_count, phase}), 0);
    end

    // Full byte, no stuffing: strobes 4,12,20,29,37,45,54,62; byte at 62.
    run_packet(64, -1, -1, -1, 30, 5);
    check("byte_done_bit_count", int'(bit_count), 0);
    drop_and_check("drop_after_byte");

    // Stuffed third bit: strobe at 20 without shift, byte delayed to 70.
    run_packet(72, 19, -1, -1, 20, 20);
    check("stuffed_byte_bit_count", int'(bit_count), 0);
    drop_and_check("drop_after_stuffed");

    // Drop after 5 counted bits, then a fresh packet starts from bit 0.
    run_packet(40, -1, -1, -1, 39, 14);
    check("partial_bit_count", int'(bit_count), 5);
    drop_and_check("drop_partial");
    run_packet(64, -1, -1, -1, 62, 12);
    drop_and_check("restart_after_drop");

    // Asynchronous reset mid-byte with bit_count = 6.
    run_packet(48, -1, -1, -1, 47, 22);
    check("pre_reset_bit_count", int'(bit_count), 6);
    #1 n_rst = 1'b0;
    #1;
    check("async_reset_outputs", int'({sample_strobe, shift_enable, byte_received, bit_count, phase}), 0);
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_outputs", int'({sample_strobe, shift_enable, byte_received, bit_count, phase}), 0);
    run_packet(64, -1, -1, -1, 1, 1);
    check("post_reset_byte_bit_count", int'(bit_count), 0);
    drop_and_check("drop_after_reset");

    // Line edges at cycles 10 and 38 (the second lands on a sample point when resync is enabled).
`ifdef RX_TIMER_RESYNC_EN
    run_packet(64, -1, 10, 38, 11, 1);
`else
    run_packet(64, -1, 10, 38, 11, 11);
`endif
    drop_and_check("drop_after_edges");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_bit_timer.md
# rx_bit_timer

Receive-side bit timing for the USB full-speed endpoint: recovers 12 Mbps bit timing from the 100 MHz clock using the same 25-clock, three-bit frame (8/8/9 clocks) the transmit path uses. Generates a mid-bit sample strobe for the NRZI decoder, a shift strobe for the RX shift register, and a byte-complete pulse for the RX controller. Optionally re-aligns its phase on every line transition. Sits between the D+/D− edge detector/bit unstuffer and the RX shift register/controller.

## Interface
- SAMPLE_OFFSET, 3: clocks after each bit boundary at which the line is sampled (legal 0..7)
- BITS_PER_BYTE, 8: counted bits per byte_received pulse (legal 2..15)
- clk  in  1  system clock, 100 MHz
- n_rst  in  1  reset, asynchronous, active-low
- receiving  in  1  level; high while a packet is being received; low forces idle
- d_edge  in  1  one-clock pulse, synchronized D+ transition detected this cycle
- unstuff  in  1  level; high means the bit at the current sample point is a stuffed bit
- sample_strobe  out  1  one-clock pulse for every sampled bit, stuffed or not
- shift_enable  out  1  one-clock pulse for every counted (non-stuffed) bit
- byte_received  out  1  one-clock pulse when BITS_PER_BYTE counted bits complete
- bit_count  out  4  counted bits in current byte, 0..BITS_PER_BYTE−1
- phase  out  5  current frame phase, 0..24

## Operation
- Phase register p (5 b): held 0 while receiving=0; while receiving=1 increments each clock, 24→0 wraps.
- Bit boundaries at p = 0, 8, 16 (bit lengths 8, 8, 9). Sample points S = {SAMPLE_OFFSET, 8+SAMPLE_OFFSET, 16+SAMPLE_OFFSET}.
- Sample condition hit = receiving && (p ∈ S) && !resync, where resync = d_edge && receiving (resync only with macro).
- On hit: sample_strobe=1 next cycle. If unstuff=0: shift_enable=1 next cycle and bit_count advances; if bit_count==BITS_PER_BYTE−1, bit_count→0 and byte_received=1 next cycle (same cycle as that shift_enable). If unstuff=1: sample_strobe only; bit_count unchanged.
- Resync: d_edge marks a bit boundary; p_next=1 (edge cycle counts as phase 0). Resync takes priority over wrap and over a coincident sample point (that sample is dropped).
- receiving falls: next cycle p=0, bit_count=0, all strobes 0; partial byte discarded, no byte_received.
- All outputs registered. Reset values: sample_strobe=0, shift_enable=0, byte_received=0, bit_count=0, phase=0.

## Timing
- Receiving rises in cycle 0 (p=0): first sample point p=3 in cycle 3, sample_strobe cycle 4; then cycles 12, 20, 29, 37, 45, … (8,8,9 spacing) absent edges.
- Latency sample point → strobes: exactly 1 clock.
- d_edge in cycle k: p=1 in k+1; next sample point at p=3 in cycle k+3, strobe k+4.
- unstuff sampled only in the hit cycle; ignored otherwise.
- Async n_rst mid-packet: all state 0 immediately; resumes from p=0 on first clock after release with receiving=1.

## Configuration
- RX_TIMER_RESYNC_EN defined: resync on d_edge as above.
- Not defined: d_edge ignored; phase free-runs from receiving rise; no samples dropped.

## Structure
- Shared package usb_rx_pkg: FRAME_LEN=25, bit-boundary constants 0/8/16, typedef phase_t (logic [4:0]), typedef bitcnt_t (logic [3:0]).
- One sub-module rx_bit_counter: bit_count/byte_received logic, inputs shift-hit and clear; phase logic stays in top.

## Test plan
- Reset held, then released with receiving=0 for 10 cycles -> all outputs 0, phase=0.
- receiving=1 at cycle 0, no edges, unstuff=0 -> sample_strobe/shift_enable at cycles 4, 12, 20, 29, …; byte_received with the 8th shift_enable at cycle 62; bit_count 0 after.
- unstuff=1 at the 3rd sample point -> sample_strobe at cycle 20 without shift_enable; bit_count stays 2; byte_received delayed to cycle 70.
- (RX_TIMER_RESYNC_EN) d_edge at cycle 10 (p=10) -> p=1 at cycle 11, strobe at cycle 14; d_edge coincident with p=3 -> no strobe that bit.
- receiving dropped after 5 counted bits -> next cycle bit_count=0, phase=0, no byte_received; new packet restarts from bit 0.
- n_rst asserted asynchronously mid-byte (bit_count=6) -> outputs 0 immediately; after release full byte needs 8 new shifts.
